// File: rtl/mul_pkg.sv
// Shared types for the multiplier datapath: product width, product type and the
// accumulator FSM state encoding.
package mul_pkg;

  localparam int PROD_W = 16;

  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_e;

endpackage : mul_pkg

// File: rtl/mul_accum_if.sv
// Product-in / frame-result-out handshake bundle for mul_accum.
// master drives products and consumes results; slave is the accumulator.
interface mul_accum_if
  import mul_pkg::*;
#(
  parameter int ACC_W = 24
);

  logic             in_valid;
  logic             in_ready;
  prod_t            in_prod;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [7:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface : mul_accum_if

// File: rtl/mul_accum.sv
// Frame accumulator behind the multiplier: sums unsigned products over up to
// FRAME_LEN beats (or until in_last) and hands the result out on valid/ready.
//
// state | meaning
// ACC   | accepting products, in_ready=1
// DONE  | result held on the output port, in_ready=0
module mul_accum
  import mul_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  mul_accum_if.slave bus
);

  localparam logic [7:0] FRAME_CNT = 8'(FRAME_LEN);

  acc_state_e       state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf;

  logic             accept;
  logic             close;
  logic [ACC_W:0]   sum_ext;
  logic [7:0]       cnt_nxt;
  logic             ovf_nxt;

  assign accept  = bus.in_valid && (state == ACC);
  // One extra bit on the adder exposes the carry out of the accumulator.
  assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
  assign cnt_nxt = cnt + 8'd1;
  assign ovf_nxt = ovf | sum_ext[ACC_W];
  assign close   = accept && ((cnt_nxt == FRAME_CNT) || bus.in_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACC;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= sum_ext[ACC_W-1:0];
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
          end
          if (close) begin
            state         <= DONE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b1;
            bus.out_sum   <= sum_ext[ACC_W-1:0];
            bus.out_count <= cnt_nxt;
            bus.out_ovf   <= ovf_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= ACC;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state         <= ACC;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : mul_accum

// File: tb/tb_mul_accum.sv
// Directed bench for mul_accum: default instance (24-bit, 16 beats) plus a
// narrow instance (16-bit, 2 beats) for the wrap/overflow case.
module tb_mul_accum;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mul_accum_if #(.ACC_W(24)) a ();
  mul_accum_if #(.ACC_W(16)) b ();

  mul_accum #(.ACC_W(24), .FRAME_LEN(16)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  mul_accum #(.ACC_W(16), .FRAME_LEN(2))  dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat_a(input prod_t p, input logic last);
    a.in_valid = 1'b1;
    a.in_prod  = p;
    a.in_last  = last;
    tick();
    a.in_valid = 1'b0;
    a.in_last  = 1'b0;
  endtask

  task automatic beat_b(input prod_t p, input logic last);
    b.in_valid = 1'b1;
    b.in_prod  = p;
    b.in_last  = last;
    tick();
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a.in_valid = 1'b0; a.in_prod = '0; a.in_last = 1'b0; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_prod = '0; b.in_last = 1'b0; b.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_in_ready",  32'(a.in_ready),  32'd1);
    check("rst_out_valid", 32'(a.out_valid), 32'd0);
    check("rst_out_sum",   32'(a.out_sum),   32'd0);
    check("rst_out_count", 32'(a.out_count), 32'd0);
    check("rst_out_ovf",   32'(a.out_ovf),   32'd0);

    // full frame: 16 beats of 3
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("full_no_early_valid", 32'(a.out_valid), 32'd0);
      beat_a(16'd3, 1'b0);
    end
    check("full_valid", 32'(a.out_valid), 32'd1);
    check("full_sum",   32'(a.out_sum),   32'd48);
    check("full_count", 32'(a.out_count), 32'd16);
    check("full_ovf",   32'(a.out_ovf),   32'd0);
    check("full_in_ready_low", 32'(a.in_ready), 32'd0);
    tick();
    check("full_valid_one_cycle", 32'(a.out_valid), 32'd0);
    check("full_in_ready_back",   32'(a.in_ready),  32'd1);

    // early close with in_last
    beat_a(16'd10, 1'b0);
    beat_a(16'd20, 1'b0);
    check("early_not_yet", 32'(a.out_valid), 32'd0);
    beat_a(16'd30, 1'b1);
    check("early_valid", 32'(a.out_valid), 32'd1);
    check("early_sum",   32'(a.out_sum),   32'd60);
    check("early_count", 32'(a.out_count), 32'd3);
    tick();
    check("early_consumed", 32'(a.out_valid), 32'd0);

    // backpressure: hold result for 5 cycles while upstream pushes
    a.out_ready = 1'b0;
    beat_a(16'd5, 1'b0);
    beat_a(16'd5, 1'b1);
    a.in_valid = 1'b1;
    a.in_prod  = 16'd100;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", 32'(a.out_valid), 32'd1);
      check("bp_in_ready",   32'(a.in_ready),  32'd0);
      check("bp_sum_stable", 32'(a.out_sum),   32'd10);
      check("bp_count",      32'(a.out_count), 32'd2);
      tick();
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    tick();
    check("bp_released",  32'(a.out_valid), 32'd0);
    check("bp_ready_back", 32'(a.in_ready), 32'd1);
    beat_a(16'd1, 1'b0);
    beat_a(16'd2, 1'b1);
    check("bp_next_sum",   32'(a.out_sum),   32'd3);
    check("bp_next_count", 32'(a.out_count), 32'd2);
    tick();

    // overflow on the narrow instance
    beat_b(16'hFFFF, 1'b0);
    beat_b(16'h0002, 1'b0);
    check("ovf_valid", 32'(b.out_valid), 32'd1);
    check("ovf_sum",   32'(b.out_sum),   32'h0001);
    check("ovf_flag",  32'(b.out_ovf),   32'd1);
    check("ovf_count", 32'(b.out_count), 32'd2);
    tick();
    beat_b(16'd1, 1'b0);
    beat_b(16'd1, 1'b0);
    check("ovf2_valid", 32'(b.out_valid), 32'd1);
    check("ovf2_sum",   32'(b.out_sum),   32'd2);
    check("ovf2_flag",  32'(b.out_ovf),   32'd0);
    tick();

    // gapped input: in_valid on alternate cycles
    a.in_prod = 16'd1;
    for (int i = 0; i < 31; i++) begin
      a.in_valid = (i % 2 == 0);
      tick();
    end
    a.in_valid = 1'b0;
    check("gap_valid", 32'(a.out_valid), 32'd1);
    check("gap_count", 32'(a.out_count), 32'd16);
    check("gap_sum",   32'(a.out_sum),   32'd16);
    tick();

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) beat_a(16'd7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(a.out_valid), 32'd0);
    check("mid_rst_ready", 32'(a.in_ready),  32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == 11) check("mid_no_stale_result", 32'(a.out_valid), 32'd0);
      beat_a(16'd1, 1'b0);
    end
    check("mid_valid", 32'(a.out_valid), 32'd1);
    check("mid_sum",   32'(a.out_sum),   32'd16);
    check("mid_count", 32'(a.out_count), 32'd16);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mul_accum
